// File: rtl/layer_priority_compositor.sv
// -----------------------------------------------------------------------------
// layer_priority_compositor
//
// Merges NUM_LAYERS sprite/board layers into one output pixel per cycle using a
// runtime priority table. The table is written into a shadow copy and becomes
// active only on startOfFrame, so an order change never tears a frame.
// It also reports, once per frame, which layers overlapped layer 0 (cue ball)
// during the previous frame.
//
// Pipeline: stage 1 registers gated draw requests, colours and pixelValid;
// stage 2 resolves priority and registers the outputs. Latency is 2 clk, with
// one pixel per cycle and no stall.
//
// Optional feature (macro LAYER_TRANSPARENT_KEY_EN):
//   When defined, a layer pixel whose colour equals TRANSPARENT_COLOR is
//   treated as not drawn for display selection. Collision detection still
//   uses the raw draw requests.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   layerDR        in   [NUM_LAYERS]          draw request per layer
//   layerRGB       in   [NUM_LAYERS*COLOR_W]  layer i colour at [i*COLOR_W +: COLOR_W]
//   pixelValid     in   pixel is inside the active display area
//   startOfFrame   in   one-cycle pulse during blanking
//   layerEnable    in   [NUM_LAYERS]          per-layer display enable
//   prioWrEn       in   write one shadow priority slot
//   prioWrIdx      in   [IDX_W] slot to write (slot 0 = highest priority)
//   prioWrLayer    in   [IDX_W] layer stored into that slot
//   RGBOut         out  [COLOR_W] composited pixel
//   RGBValid       out  RGBOut belongs to a valid pixel
//   topLayer       out  [IDX_W] layer selected for RGBOut
//   anyDrawn       out  at least one displayed layer drew this pixel
//   collisionFlags out  [NUM_LAYERS] bit i = layers 0 and i overlapped last frame
// -----------------------------------------------------------------------------
module layer_priority_compositor #(
    parameter int unsigned        NUM_LAYERS        = 8,
    parameter int unsigned        COLOR_W           = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR          = '0,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = {COLOR_W{1'b1}},
    localparam int unsigned       IDX_W             = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LAYERS-1:0]         layerDR,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layerRGB,
    input  logic                          pixelValid,
    input  logic                          startOfFrame,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
    input  logic                          prioWrEn,
    input  logic [IDX_W-1:0]              prioWrIdx,
    input  logic [IDX_W-1:0]              prioWrLayer,
    output logic [COLOR_W-1:0]            RGBOut,
    output logic                          RGBValid,
    output logic [IDX_W-1:0]              topLayer,
    output logic                          anyDrawn,
    output logic [NUM_LAYERS-1:0]         collisionFlags
);

    // When NUM_LAYERS is a power of two every index value is in range.
    localparam bit IDX_FULL = ((1 << IDX_W) == NUM_LAYERS);

    // ------------------------------------------------------------------
    // Priority tables (shadow written by software, active used by stage 2)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] shadow_q [NUM_LAYERS];
    logic [IDX_W-1:0] shadow_d [NUM_LAYERS];
    logic [IDX_W-1:0] active_q [NUM_LAYERS];
    logic [IDX_W-1:0] active_d [NUM_LAYERS];
    logic             wr_ok_c;

    // Out-of-range slot or layer indices drop the write.
    always_comb begin
        wr_ok_c = prioWrEn;
        if (!IDX_FULL) begin
            wr_ok_c = prioWrEn
                      && (32'(prioWrIdx)   < NUM_LAYERS)
                      && (32'(prioWrLayer) < NUM_LAYERS);
        end
    end

    // Active copies the pre-write shadow, so a coincident write waits a frame.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (startOfFrame) begin
            active_d = shadow_q;
        end
        if (wr_ok_c) begin
            shadow_d[prioWrIdx] = prioWrLayer;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
                shadow_q[k] <= IDX_W'(k);
                active_q[k] <= IDX_W'(k);
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: gated draw requests, colours, valid
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0]         drawn_c;
    logic [NUM_LAYERS-1:0]         s1_drawn_q;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb_q;
    logic                          s1_valid_q;

    always_comb begin
        drawn_c = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
`ifdef LAYER_TRANSPARENT_KEY_EN
            drawn_c[i] = layerDR[i] & layerEnable[i] & pixelValid
                         & (layerRGB[i*COLOR_W +: COLOR_W] != TRANSPARENT_COLOR);
`else
            drawn_c[i] = layerDR[i] & layerEnable[i] & pixelValid;
`endif
        end
    end

`ifndef LAYER_TRANSPARENT_KEY_EN
    // The colour key only matters when the transparency feature is built in.
    logic unused_transparent_c;
    assign unused_transparent_c = ^TRANSPARENT_COLOR;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_drawn_q <= '0;
            s1_rgb_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_drawn_q <= drawn_c;
            s1_rgb_q   <= layerRGB;
            s1_valid_q <= pixelValid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: first active slot whose layer drew wins
    // ------------------------------------------------------------------
    logic                 found_c;
    logic [IDX_W-1:0]     win_idx_c;
    logic [COLOR_W-1:0]   win_rgb_c;
    logic [COLOR_W-1:0]   rgb_d,   rgb_q;
    logic                 valid_d, valid_q;
    logic [IDX_W-1:0]     top_d,   top_q;
    logic                 any_d,   any_q;

    // Duplicate slots are harmless: only the first hit is taken.
    always_comb begin
        found_c   = 1'b0;
        win_idx_c = '0;
        win_rgb_c = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (!found_c && s1_drawn_q[active_q[k]]) begin
                found_c   = 1'b1;
                win_idx_c = active_q[k];
                win_rgb_c = s1_rgb_q[32'(active_q[k]) * COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        rgb_d   = '0;
        top_d   = '0;
        any_d   = 1'b0;
        valid_d = s1_valid_q;
        if (s1_valid_q) begin
            if (found_c) begin
                rgb_d = win_rgb_c;
                top_d = win_idx_c;
                any_d = 1'b1;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
            top_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            top_q   <= top_d;
            any_q   <= any_d;
        end
    end

    // ------------------------------------------------------------------
    // Collision accumulation against layer 0 (raw DR, enables ignored)
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] hit_c;
    logic [NUM_LAYERS-1:0] acc_d,   acc_q;
    logic [NUM_LAYERS-1:0] flags_d, flags_q;

    always_comb begin
        hit_c = '0;
        for (int unsigned i = 1; i < NUM_LAYERS; i++) begin
            hit_c[i] = layerDR[0] & layerDR[i] & pixelValid;
        end
    end

    // Frame boundary publishes the finished frame and restarts accumulation.
    always_comb begin
        acc_d   = acc_q | hit_c;
        flags_d = flags_q;
        if (startOfFrame) begin
            flags_d = acc_q;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign RGBOut         = rgb_q;
    assign RGBValid       = valid_q;
    assign topLayer       = top_q;
    assign anyDrawn       = any_q;
    assign collisionFlags = flags_q;

endmodule

// File: tb/tb_layer_priority_compositor.sv
// Self-checking bench for layer_priority_compositor: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_layer_priority_compositor;

    localparam int N  = 8;
    localparam int CW = 8;
    localparam int IW = 3;
    localparam logic [CW-1:0] BG = 8'h00;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      layerDR;
    logic [N*CW-1:0]   layerRGB;
    logic              pixelValid;
    logic              startOfFrame;
    logic [N-1:0]      layerEnable;
    logic              prioWrEn;
    logic [IW-1:0]     prioWrIdx;
    logic [IW-1:0]     prioWrLayer;
    logic [CW-1:0]     RGBOut;
    logic              RGBValid;
    logic [IW-1:0]     topLayer;
    logic              anyDrawn;
    logic [N-1:0]      collisionFlags;

    layer_priority_compositor dut (
        .clk            (clk),
        .reset          (reset),
        .layerDR        (layerDR),
        .layerRGB       (layerRGB),
        .pixelValid     (pixelValid),
        .startOfFrame   (startOfFrame),
        .layerEnable    (layerEnable),
        .prioWrEn       (prioWrEn),
        .prioWrIdx      (prioWrIdx),
        .prioWrLayer    (prioWrLayer),
        .RGBOut         (RGBOut),
        .RGBValid       (RGBValid),
        .topLayer       (topLayer),
        .anyDrawn       (anyDrawn),
        .collisionFlags (collisionFlags)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // ---------------- behavioural model ----------------
    int          m_active [N];
    int          m_shadow [N];
    bit [N-1:0]  m_pix_show;      // layers eligible for display, one cycle old
    bit [CW-1:0] m_pix_col [N];
    bit          m_pix_valid;
    bit [N-1:0]  m_acc, m_flags;
    bit [CW-1:0] e_rgb;
    bit          e_valid, e_any;
    int          e_top;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_active[k]  = k;
            m_shadow[k]  = k;
            m_pix_col[k] = '0;
        end
        m_pix_show  = '0;
        m_pix_valid = 0;
        m_acc = '0; m_flags = '0;
        e_rgb = '0; e_valid = 0; e_any = 0; e_top = 0;
    endtask

    task automatic compare_all();
        check("RGBOut",         32'(RGBOut),         32'(e_rgb));
        check("RGBValid",       32'(RGBValid),       32'(e_valid));
        check("topLayer",       32'(topLayer),       32'(e_top));
        check("anyDrawn",       32'(anyDrawn),       32'(e_any));
        check("collisionFlags", 32'(collisionFlags), 32'(m_flags));
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic step();
        bit [CW-1:0] n_rgb; bit n_any; int n_top;
        bit [N-1:0]  n_show; bit [CW-1:0] n_col [N];
        int n_active [N]; int n_shadow [N];
        bit [N-1:0] n_acc, n_flags;
        n_rgb = '0; n_any = 0; n_top = 0;
        if (m_pix_valid) begin
            n_rgb = BG;
            for (int k = N-1; k >= 0; k--) begin
                if (m_pix_show[m_active[k]]) begin
                    n_rgb = m_pix_col[m_active[k]];
                    n_top = m_active[k];
                    n_any = 1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            n_col[i]  = layerRGB[i*CW +: CW];
            n_show[i] = layerDR[i] && layerEnable[i] && pixelValid;
`ifdef LAYER_TRANSPARENT_KEY_EN
            if (n_col[i] == 8'hFF) n_show[i] = 0;
`endif
        end
        n_active = startOfFrame ? m_shadow : m_active;
        n_shadow = m_shadow;
        if (prioWrEn && int'(prioWrIdx) < N && int'(prioWrLayer) < N)
            n_shadow[prioWrIdx] = int'(prioWrLayer);
        n_acc = m_acc; n_flags = m_flags;
        if (startOfFrame) begin
            n_flags = m_acc; n_acc = '0;
        end else if (pixelValid && layerDR[0]) begin
            n_acc = m_acc | (layerDR & ~N'(1));
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            e_rgb = n_rgb; e_any = n_any; e_top = n_top; e_valid = m_pix_valid;
            m_pix_show = n_show; m_pix_col = n_col; m_pix_valid = pixelValid;
            m_active = n_active; m_shadow = n_shadow;
            m_acc = n_acc; m_flags = n_flags;
        end
        #1;
        compare_all();
    endtask

    task automatic set_pair(input logic [CW-1:0] c2, input logic [CW-1:0] c5);
        layerRGB = '0;
        layerRGB[2*CW +: CW] = c2;
        layerRGB[5*CW +: CW] = c5;
        layerDR = 8'b0010_0100;
    endtask

    task automatic frame_boundary();
        logic [N-1:0] dr_save;
        dr_save = layerDR;
        pixelValid = 0; startOfFrame = 1; step();
        startOfFrame = 0; prioWrEn = 0; step();
        layerDR = dr_save;
    endtask

    initial begin
        reset = 1; layerDR = '0; layerRGB = '0; pixelValid = 0; startOfFrame = 0;
        layerEnable = '1; prioWrEn = 0; prioWrIdx = '0; prioWrLayer = '0;
        model_reset();
        step(); step();
        check("reset_RGBOut", 32'(RGBOut), 32'h0);
        check("reset_flags",  32'(collisionFlags), 32'h0);
        reset = 0;

        // Identity order: layer 2 beats layer 5.
        set_pair(8'h1C, 8'hE0); pixelValid = 1;
        step(); step();
        check("ident_rgb", 32'(RGBOut), 32'h1C);
        check("ident_top", 32'(topLayer), 32'd2);
        check("ident_any", 32'(anyDrawn), 32'd1);
        check("ident_vld", 32'(RGBValid), 32'd1);

        // Mid-frame write stays in the shadow until the frame boundary.
        prioWrEn = 1; prioWrIdx = 3'd0; prioWrLayer = 3'd5; step();
        prioWrEn = 0; step(); step(); step();
        check("shadow_hold_rgb", 32'(RGBOut), 32'h1C);
        frame_boundary();
        pixelValid = 1; step(); step();
        check("commit_rgb", 32'(RGBOut), 32'hE0);
        check("commit_top", 32'(topLayer), 32'd5);

        // Write coincident with startOfFrame lands one frame late.
        pixelValid = 0; startOfFrame = 1;
        prioWrEn = 1; prioWrIdx = 3'd0; prioWrLayer = 3'd2; step();
        startOfFrame = 0; prioWrEn = 0; pixelValid = 1; step(); step(); step();
        check("coinc_absent_rgb", 32'(RGBOut), 32'hE0);
        frame_boundary();
        pixelValid = 1; step(); step();
        check("coinc_applied_rgb", 32'(RGBOut), 32'h1C);
        check("coinc_applied_top", 32'(topLayer), 32'd2);

        // Per-layer enable and background.
        layerEnable[2] = 0; step(); step();
        check("enable_rgb", 32'(RGBOut), 32'hE0);
        layerDR = '0; step(); step();
        check("bg_rgb", 32'(RGBOut), 32'(BG));
        check("bg_any", 32'(anyDrawn), 32'd0);
        check("bg_vld", 32'(RGBValid), 32'd1);
        layerEnable = '1;

        // Collisions: 0 and 3 overlap on 4 pixels.
        frame_boundary();
        pixelValid = 1; layerDR = 8'b0000_1001;
        repeat (4) step();
        layerDR = '0; step();
        frame_boundary();
        check("coll_flags", 32'(collisionFlags), 32'h08);
        pixelValid = 1; layerDR = 8'b0000_0001; repeat (3) step();
        layerDR = 8'b0000_1000; step();
        check("coll_hold", 32'(collisionFlags), 32'h08);
        frame_boundary();
        check("coll_clear", 32'(collisionFlags), 32'h00);

`ifdef LAYER_TRANSPARENT_KEY_EN
        set_pair(8'hFF, 8'hE0); pixelValid = 1; step(); step();
        check("transp_rgb", 32'(RGBOut), 32'hE0);
        check("transp_top", 32'(topLayer), 32'd5);
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            pixelValid   = ($urandom_range(0, 3) != 0);
            startOfFrame = !pixelValid && ($urandom_range(0, 5) == 0);
            layerDR      = N'($urandom);
            for (int i = 0; i < N; i++)
                layerRGB[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? 8'hFF : CW'($urandom);
            layerEnable  = N'($urandom) | N'($urandom);
            prioWrEn     = ($urandom_range(0, 4) == 0);
            prioWrIdx    = IW'($urandom);
            prioWrLayer  = IW'($urandom);
            step();
        end
        prioWrEn = 0; startOfFrame = 0;

        // Asynchronous reset with the pipeline full.
        pixelValid = 1; layerDR = '1; layerEnable = '1; step(); step();
        reset = 1; #1;
        model_reset();
        compare_all();
        check("rst_mid_rgb", 32'(RGBOut), 32'h0);
        check("rst_mid_vld", 32'(RGBValid), 32'h0);
        step();
        reset = 0;
        set_pair(8'h1C, 8'hE0); pixelValid = 1; step(); step();
        check("rst_ident_rgb", 32'(RGBOut), 32'h1C);
        check("rst_ident_top", 32'(topLayer), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
